// File: rtl/pomdp_pkg.sv
// rtl/pomdp_pkg.sv - shared constants, state encoding and Q8.8 helpers for the POMDP policy executor
package pomdp_pkg;

  localparam int N_PT  = 16;
  localparam int FRAC  = 8;
  localparam int N_ACT = 3;
  localparam int N_ST  = 2;
  localparam int N_OBS = 2;

  localparam logic [15:0] ONE = 16'h0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ACT,
    S_UPDATE,
    S_DIV
  } state_t;

  // Clamp a widened product back to an unsigned Q8.8 word.
  function automatic logic [15:0] sat_q88(input logic [40:0] v);
    return (|v[40:16]) ? 16'hFFFF : v[15:0];
  endfunction

endpackage

// File: rtl/q88_divider.sv
// rtl/q88_divider.sv - fixed 16-cycle restoring divider computing (num << FRAC) / den for num <= den
module q88_divider #(
  parameter int FRAC = pomdp_pkg::FRAC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num,
  input  logic [16:0] den,
  output logic        done,
  output logic [15:0] quo
);

  logic        running;
  logic [3:0]  cnt;
  logic [16:0] rem;
  logic [15:0] sh;
  logic [14:0] q;
  logic [17:0] rem_sh;
  logic [16:0] trial;
  logic        ge;

  // The top FRAC dividend bits seed the remainder; since num <= den the seed is
  // already below den, so 16 steps yield the whole quotient.
  always_comb begin
    rem_sh = {rem, sh[15]};
    ge     = (rem_sh >= {1'b0, den});
    trial  = rem_sh[16:0] - den;
  end

  assign done = running && (cnt == 4'd15);
  assign quo  = {q, ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      sh      <= '0;
      q       <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      rem     <= 17'(num >> (16 - FRAC));
      sh      <= 16'(num << FRAC);
      q       <= '0;
    end else if (running) begin
      rem <= ge ? trial : rem_sh[16:0];
      sh  <= sh << 1;
      q   <= quo[14:0];
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) running <= 1'b0;
    end
  end

endmodule

// File: rtl/policy_exec.sv
// rtl/policy_exec.sv - POMDP policy executor: alpha-vector argmax, action hold, Bayesian belief update
module policy_exec #(
  parameter int N_PT = pomdp_pkg::N_PT,
  parameter int FRAC = pomdp_pkg::FRAC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [15:0]              alpha_in    [N_PT][2],
  input  logic [1:0]               action_in   [N_PT],
  input  logic [15:0]              trans       [pomdp_pkg::N_ACT][pomdp_pkg::N_ST][pomdp_pkg::N_ST],
  input  logic [15:0]              observe     [pomdp_pkg::N_ACT][pomdp_pkg::N_ST][pomdp_pkg::N_OBS],
  input  logic                     start,
  input  logic [15:0]              belief_init [2],
  input  logic                     obs_valid,
  input  logic                     obs,
  input  logic                     stop,
  output logic                     busy,
  output logic                     act_valid,
  output logic [1:0]               action,
  output logic [$clog2(N_PT)-1:0]  best_idx,
  output logic [15:0]              belief      [2],
  output logic                     obs_err
);
  import pomdp_pkg::*;

  localparam int IW   = $clog2(N_PT);
  localparam int LAST = N_PT;

  state_t state, state_nx;

  logic [15:0]       alpha_t [N_PT][2];
  logic [1:0]        act_t   [N_PT];
  logic [IW:0]       idx;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     cand;
  logic signed [33:0] max_val;
  logic signed [33:0] a0, a1, b0s, b1s, val;
  logic              obs_lat;

  logic [1:0]  ai;
  logic [32:0] psum [2];
  logic [24:0] p    [2];
  logic [40:0] xw   [2];
  logic [40:0] xs   [2];
  logic [15:0] x    [2];
  logic [16:0] sum;

  logic        div_start;
  logic        div_done;
  logic [15:0] div_q;

  assign busy      = (state != S_IDLE);
  assign act_valid = (state == S_ACT);
  assign sel       = idx[IW-1:0];

  // Full-precision dot product: signed alpha times zero-extended belief.
  assign a0  = 34'($signed(alpha_t[sel][0]));
  assign a1  = 34'($signed(alpha_t[sel][1]));
  assign b0s = 34'(belief[0]);
  assign b1s = 34'(belief[1]);
  assign val = a0 * b0s + a1 * b1s;

  // Action 3 has no model row: force both likelihoods to zero so it takes the zero-normalizer path.
  always_comb begin
    ai = (action == 2'd3) ? 2'd0 : action;
    for (int j = 0; j < 2; j++) begin
      psum[j] = 33'(trans[ai][0][j]) * 33'(belief[0]) + 33'(trans[ai][1][j]) * 33'(belief[1]);
      p[j]    = 25'(psum[j] >> FRAC);
      xw[j]   = 41'(observe[ai][j][obs_lat]) * 41'(p[j]);
      xs[j]   = xw[j] >> FRAC;
      x[j]    = (action == 2'd3) ? 16'd0 : sat_q88(xs[j]);
    end
    sum = {1'b0, x[0]} + {1'b0, x[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = S_SELECT;
      S_SELECT: if (idx == LAST[IW:0]) state_nx = S_ACT;
      S_ACT: begin
        if (stop)           state_nx = S_IDLE;
        else if (obs_valid) state_nx = S_UPDATE;
      end
      S_UPDATE: begin
        if (sum == '0) begin
          state_nx = S_SELECT;
        end else begin
          state_nx  = S_DIV;
          div_start = 1'b1;
        end
      end
      S_DIV:    if (div_done) state_nx = S_SELECT;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PT; i++) begin
        alpha_t[i][0] <= '0;
        alpha_t[i][1] <= '0;
        act_t[i]      <= '0;
      end
      belief[0] <= '0;
      belief[1] <= '0;
      obs_err   <= 1'b0;
      action    <= '0;
      best_idx  <= '0;
      idx       <= '0;
      max_val   <= '0;
      cand      <= '0;
      obs_lat   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            for (int i = 0; i < N_PT; i++) begin
              alpha_t[i][0] <= alpha_in[i][0];
              alpha_t[i][1] <= alpha_in[i][1];
              act_t[i]      <= action_in[i];
            end
          end
          if (start) begin
            belief[0] <= belief_init[0];
            belief[1] <= belief_init[1];
            obs_err   <= 1'b0;
            idx       <= '0;
          end
        end
        S_SELECT: begin
          // Extra cycle at idx == N_PT publishes the winner to the outputs.
          if (idx == LAST[IW:0]) begin
            best_idx <= cand;
            action   <= act_t[cand];
          end else begin
            idx <= idx + 1'b1;
            if (idx == '0 || val > max_val) begin
              max_val <= val;
              cand    <= sel;
            end
          end
        end
        S_ACT: if (!stop && obs_valid) obs_lat <= obs;
        S_UPDATE: begin
          idx <= '0;
          if (sum == '0) obs_err <= 1'b1;
        end
        S_DIV: begin
          if (div_done) begin
            belief[0] <= div_q;
            belief[1] <= ONE - div_q;
          end
        end
        default: ;
      endcase
    end
  end

  q88_divider #(.FRAC(FRAC)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (x[0]),
    .den   (sum),
    .done  (div_done),
    .quo   (div_q)
  );

endmodule

// File: tb/tb_policy_exec.sv
// tb/tb_policy_exec.sv - directed scoreboard bench for policy_exec
module tb_policy_exec;

  logic        clk = 1'b0;
  logic        rst_n, load, start, obs_valid, obs, stop;
  logic [15:0] alpha_in    [16][2];
  logic [1:0]  action_in   [16];
  logic [15:0] trans       [3][2][2];
  logic [15:0] observe     [3][2][2];
  logic [15:0] belief_init [2];
  logic        busy, act_valid, obs_err;
  logic [1:0]  action;
  logic [3:0]  best_idx;
  logic [15:0] belief      [2];

  always #5 clk = ~clk;

  policy_exec dut (
    .clk(clk), .rst_n(rst_n), .load(load), .alpha_in(alpha_in), .action_in(action_in),
    .trans(trans), .observe(observe), .start(start), .belief_init(belief_init),
    .obs_valid(obs_valid), .obs(obs), .stop(stop), .busy(busy), .act_valid(act_valid),
    .action(action), .best_idx(best_idx), .belief(belief), .obs_err(obs_err)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [1:0]  act;
    logic [15:0] b0;
    logic [15:0] b1;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
  endtask

  task automatic push_exp(input logic [3:0] i, input logic [1:0] a, input logic [15:0] b0,
                          input logic [15:0] b1, input logic e, input int lat);
    exp_t t;
    t.idx = i; t.act = a; t.b0 = b0; t.b1 = b1; t.err = e; t.lat = lat;
    sb.push_back(t);
  endtask

  // Counts edges after a reference edge until act_valid, then scores against the queue head.
  task automatic wait_act(input string tag);
    exp_t e;
    int   n = 0;
    while (act_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"},    n,          e.lat);
    chk({tag, "_idx"},    best_idx,   e.idx);
    chk({tag, "_action"}, action,     e.act);
    chk({tag, "_b0"},     belief[0],  e.b0);
    chk({tag, "_b1"},     belief[1],  e.b1);
    chk({tag, "_err"},    obs_err,    e.err);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    load  = 1'b0;
    wait_act(tag);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic clear_alpha();
    for (int i = 0; i < 16; i++) begin
      alpha_in[i][0] = 16'h0; alpha_in[i][1] = 16'h0; action_in[i] = 2'd0;
    end
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; start = 1'b0; obs_valid = 1'b0; obs = 1'b0; stop = 1'b0;
    clear_alpha();
    for (int a = 0; a < 3; a++)
      for (int s = 0; s < 2; s++) begin
        trans[a][s][0]   = (s == 0) ? 16'h0100 : 16'h0;
        trans[a][s][1]   = (s == 1) ? 16'h0100 : 16'h0;
        observe[a][s][0] = (s == 0) ? 16'h0100 : 16'h0080;
        observe[a][s][1] = 16'h0;
      end
    belief_init[0] = 16'h0; belief_init[1] = 16'h0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_act_valid", act_valid, 0);
    chk("rst_action", action, 0);
    chk("rst_best_idx", best_idx, 0);
    chk("rst_belief0", belief[0], 0);
    chk("rst_obs_err", obs_err, 0);
    rst_n = 1'b1;
    tick();

    // Load and start in the same cycle; alpha0 wins for a belief leaning to state 0.
    alpha_in[0][0] = 16'h0100; alpha_in[1][1] = 16'h0100; action_in[0] = 2'd2;
    belief_init[0] = 16'h00C0; belief_init[1] = 16'h0040;
    push_exp(4'd0, 2'd2, 16'h00C0, 16'h0040, 1'b0, 17);
    load = 1'b1;
    do_start("basic");
    tick(); tick(); tick();
    chk("hold_act_valid", act_valid, 1);
    chk("hold_action", action, 2);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_b0", belief[0], 16'h00C0);
    chk("startstop_b1", belief[1], 16'h0040);

    // Ties keep the lowest index; a strictly larger later vector wins.
    belief_init[0] = 16'h0080; belief_init[1] = 16'h0080;
    for (int i = 0; i < 16; i++) begin
      alpha_in[i][0] = 16'h0080; alpha_in[i][1] = 16'h0080; action_in[i] = 2'((i + 1) % 4);
    end
    do_load();
    push_exp(4'd0, 2'd1, 16'h0080, 16'h0080, 1'b0, 17);
    do_start("tie");
    do_stop();
    alpha_in[5][0] = 16'h0081;
    do_load();
    push_exp(4'd5, 2'd2, 16'h0080, 16'h0080, 1'b0, 17);
    do_start("raise5");
    do_stop();

    // Negative values: the least negative vector must win.
    for (int i = 0; i < 16; i++) begin
      alpha_in[i][0] = 16'hFF00; alpha_in[i][1] = 16'hFF00;
    end
    alpha_in[9][0] = 16'hFFF0; alpha_in[9][1] = 16'h0000; action_in[9] = 2'd3;
    do_load();
    push_exp(4'd9, 2'd3, 16'h0080, 16'h0080, 1'b0, 17);
    do_start("neg");
    do_stop();

    // Belief update through the divider: (0x80,0x80) with obs 0 -> (0xAA,0x56).
    clear_alpha();
    alpha_in[0][0] = 16'h0100; alpha_in[1][1] = 16'h0100; action_in[0] = 2'd2;
    load = 1'b1;
    push_exp(4'd0, 2'd2, 16'h0080, 16'h0080, 1'b0, 17);
    do_start("upd_pre");
    obs_valid = 1'b1; obs = 1'b0;
    tick();
    obs_valid = 1'b0;
    tick();
    for (int k = 0; k < 15; k++) tick();
    chk("div_mid_b0", belief[0], 16'h0080);
    tick();
    chk("div_done_b0", belief[0], 16'h00AA);
    chk("div_done_b1", belief[1], 16'h0056);
    chk("div_done_act_valid", act_valid, 0);
    push_exp(4'd0, 2'd2, 16'h00AA, 16'h0056, 1'b0, 17);
    wait_act("upd_post");

    // Zero normalizer: obs_err set, belief kept, re-select takes 17 cycles.
    push_exp(4'd0, 2'd2, 16'h00AA, 16'h0056, 1'b1, 17);
    obs_valid = 1'b1; obs = 1'b1;
    tick();
    obs_valid = 1'b0;
    tick();
    wait_act("zero_norm");
    do_stop();
    push_exp(4'd0, 2'd2, 16'h0080, 16'h0080, 1'b0, 17);
    do_start("err_clear");
    do_stop();

    // Action code 3 has no matrix row and must also hit the zero-normalizer path.
    action_in[0] = 2'd3;
    load = 1'b1;
    push_exp(4'd0, 2'd3, 16'h0080, 16'h0080, 1'b0, 17);
    do_start("act3_pre");
    push_exp(4'd0, 2'd3, 16'h0080, 16'h0080, 1'b1, 17);
    obs_valid = 1'b1; obs = 1'b0;
    tick();
    obs_valid = 1'b0;
    tick();
    wait_act("act3_post");
    do_stop();

    // Asynchronous reset in the middle of a divide.
    action_in[0] = 2'd2;
    load = 1'b1;
    push_exp(4'd0, 2'd2, 16'h0080, 16'h0080, 1'b0, 17);
    do_start("mid_div_pre");
    obs_valid = 1'b1; obs = 1'b0;
    tick();
    obs_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_act_valid", act_valid, 0);
    chk("arst_action", action, 0);
    chk("arst_best_idx", best_idx, 0);
    chk("arst_belief0", belief[0], 0);
    chk("arst_belief1", belief[1], 0);
    chk("arst_obs_err", obs_err, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    chk("no_resume_busy", busy, 0);
    push_exp(4'd0, 2'd0, 16'h0080, 16'h0080, 1'b0, 17);
    do_start("cleared_tables");
    do_stop();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
